// File: rtl/div_hilo_ctrl.sv
// Divide sequencer and HI/LO result holder for the multicycle combinational divider.
// Holds operands stable for SETTLE_CYCLES, captures {remainder, quotient}, and handles move-to-HI/LO.
module div_hilo_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] m_in,
   output logic [31:0] div_a,
   output logic [31:0] div_m,
   input  logic [63:0] div_result,
   input  logic        hi_wr,
   input  logic        lo_wr,
   input  logic [31:0] wr_data,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic        state_dbg
);

   typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

   // Counter starts at SETTLE_CYCLES-1 so capture lands on edge E0+SETTLE_CYCLES.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] a_n, m_n, hi_n, lo_n;
   logic        done_n, dz_n;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         div_a    <= 32'd0;
         div_m    <= 32'd0;
         hi_out   <= 32'd0;
         lo_out   <= 32'd0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_a    <= a_n;
         div_m    <= m_n;
         hi_out   <= hi_n;
         lo_out   <= lo_n;
         done     <= done_n;
         div_zero <= dz_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a_n     = div_a;
      m_n     = div_m;
      hi_n    = hi_out;
      lo_n    = lo_out;
      done_n  = 1'b0;
      dz_n    = div_zero;
      case (state)
         IDLE: begin
            if (start) begin
               // Start always wins over a same-cycle move-to-HI/LO.
               a_n = a_in;
               m_n = m_in;
               if (m_in != 32'd0) begin
                  cnt_n   = CNT_LOAD;
                  dz_n    = 1'b0;
                  state_n = SETTLE;
               end else begin
                  hi_n   = a_in;
                  lo_n   = 32'hFFFF_FFFF;
                  dz_n   = 1'b1;
                  done_n = 1'b1;
               end
            end else begin
               if (hi_wr) hi_n = wr_data;
               if (lo_wr) lo_n = wr_data;
            end
         end
         SETTLE: begin
            // Operands stay frozen; start and writes are ignored until capture.
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               hi_n    = div_result[63:32];
               lo_n    = div_result[31:0];
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy      = (state == SETTLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl: directed scenarios plus randomized ops
// compared against an arithmetic reference of the HI/LO/div_zero contents and handshake timing.
module tb_div_hilo_ctrl;

   localparam int S = 4;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] a_in, m_in;
   logic [31:0] div_a, div_m;
   logic [63:0] div_result;
   logic        hi_wr, lo_wr;
   logic [31:0] wr_data;
   logic [31:0] hi_out, lo_out;
   logic        busy, done, div_zero;
   logic        state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;
   logic        exp_dz = 1'b0;

   div_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clock      (clock),
      .clear      (clear),
      .start      (start),
      .a_in       (a_in),
      .m_in       (m_in),
      .div_a      (div_a),
      .div_m      (div_m),
      .div_result (div_result),
      .hi_wr      (hi_wr),
      .lo_wr      (lo_wr),
      .wr_data    (wr_data),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Divider stand-in: truncating signed quotient, magnitude remainder.
   function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] m);
      longint sa, sm, q, r;
      sa = longint'($signed(a));
      sm = longint'($signed(m));
      if (sm == 0) return 64'h0;
      q = sa / sm;
      r = (sa < 0 ? -sa : sa) % (sm < 0 ? -sm : sm);
      return {r[31:0], q[31:0]};
   endfunction

   assign div_result = div_model(div_a, div_m);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_regs(input string tag);
      check_eq({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
      check_eq({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
      check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
   endtask

   // driver tasks
   // noise: 0 quiet, 1 start(9,3)+hi_wr DEADBEEF during settle, 2 random activity during settle
   task automatic do_divide(input logic [31:0] a, input logic [31:0] m, input int noise,
                            input logic hw, input logic lw, input logic [31:0] wd);
      logic [63:0] res;
      start = 1'b1; a_in = a; m_in = m;
      hi_wr = hw; lo_wr = lw; wr_data = wd;
      step();
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      if (m == 32'd0) begin
         exp_hi = a; exp_lo = 32'hFFFF_FFFF; exp_dz = 1'b1;
         check_eq("dz_busy", 64'(busy), 64'd0);
         check_eq("dz_done", 64'(done), 64'd1);
         check_eq("dz_div_a", 64'(div_a), 64'(a));
         check_regs("dz");
      end else begin
         res = div_model(a, m);
         exp_dz = 1'b0;
         for (int k = 0; k < S; k++) begin
            check_eq("settle_busy", 64'(busy), 64'd1);
            check_eq("settle_done", 64'(done), 64'd0);
            check_eq("settle_div_a", 64'(div_a), 64'(a));
            check_eq("settle_div_m", 64'(div_m), 64'(m));
            check_regs("settle");
            if (noise == 1) begin
               start = 1'b1; a_in = 32'd9; m_in = 32'd3;
               hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
            end else if (noise == 2) begin
               start = 1'($urandom_range(0, 1));
               a_in = $urandom; m_in = $urandom;
               hi_wr = 1'($urandom_range(0, 1));
               lo_wr = 1'($urandom_range(0, 1));
               wr_data = $urandom;
            end
            step();
         end
         start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
         exp_hi = res[63:32]; exp_lo = res[31:0];
         check_eq("cap_busy", 64'(busy), 64'd0);
         check_eq("cap_done", 64'(done), 64'd1);
         check_regs("cap");
      end
   endtask

   task automatic do_write(input logic hw, input logic lw, input logic [31:0] d);
      start = 1'b0; hi_wr = hw; lo_wr = lw; wr_data = d;
      step();
      hi_wr = 1'b0; lo_wr = 1'b0;
      if (hw) exp_hi = d;
      if (lw) exp_lo = d;
      check_eq("wr_busy", 64'(busy), 64'd0);
      check_eq("wr_done", 64'(done), 64'd0);
      check_regs("wr");
   endtask

   task automatic do_idle();
      step();
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_done", 64'(done), 64'd0);
      check_regs("idle");
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
      check_eq({tag, "_div_a"}, 64'(div_a), 64'd0);
      check_eq({tag, "_div_m"}, 64'(div_m), 64'd0);
      check_eq({tag, "_hi"}, 64'(hi_out), 64'd0);
      check_eq({tag, "_lo"}, 64'(lo_out), 64'd0);
      check_eq({tag, "_dz"}, 64'(div_zero), 64'd0);
   endtask

   task automatic reset_mid_settle();
      start = 1'b1; a_in = 32'd100; m_in = 32'd7;
      step();
      start = 1'b0;
      step();
      #3 clear = 1'b0;
      #1;
      exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
      check_all_zero("rst_mid");
      step();
      clear = 1'b1;
      for (int k = 0; k < S + 2; k++) do_idle();
   endtask

   // main sequence and scoreboard-driven random phase
   initial begin
      int op;
      logic [31:0] ra, rm;
      clear = 1'b0; start = 1'b0; a_in = '0; m_in = '0;
      hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
      #12;
      check_all_zero("in_reset");
      step();
      clear = 1'b1;
      step();
      check_all_zero("post_reset");

      do_divide(32'd100, 32'd7, 0, 1'b0, 1'b0, 32'd0);
      check_eq("d100_lo", 64'(lo_out), 64'd14);
      check_eq("d100_hi", 64'(hi_out), 64'd2);
      do_idle();
      do_divide(32'hFFFF_FF9C, 32'd7, 0, 1'b0, 1'b0, 32'd0);
      check_eq("neg_lo", 64'(lo_out), 64'hFFFF_FFF2);
      check_eq("neg_hi", 64'(hi_out), 64'd2);
      do_divide(32'd55, 32'd0, 0, 1'b0, 1'b0, 32'd0);
      check_eq("zero_hi", 64'(hi_out), 64'd55);
      do_idle();
      do_divide(32'd100, 32'd7, 1, 1'b0, 1'b0, 32'd0);
      check_eq("noise_hi", 64'(hi_out), 64'd2);
      do_write(1'b1, 1'b1, 32'h1234_5678);
      do_divide(32'd1000, 32'd10, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
      check_eq("conf_lo", 64'(lo_out), 64'd100);
      check_eq("conf_hi", 64'(hi_out), 64'd0);
      do_divide(32'd7, 32'd0, 0, 1'b0, 1'b0, 32'd0);
      do_divide(32'd8, 32'd0, 0, 1'b0, 1'b1, 32'h5555_5555);
      do_divide(32'd9, 32'd2, 0, 1'b0, 1'b0, 32'd0);
      do_idle();

      reset_mid_settle();
      do_divide(32'd20, 32'd6, 0, 1'b0, 1'b0, 32'd0);
      check_eq("fresh_lo", 64'(lo_out), 64'd3);
      check_eq("fresh_hi", 64'(hi_out), 64'd2);

      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 9);
         ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 500));
         rm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
         if (rm == 32'd0) rm = 32'd1;
         case (op)
            0, 1, 2, 3, 4: do_divide(ra, rm, 2, 1'b0, 1'b0, 32'd0);
            5:             do_divide(ra, 32'd0, 0, 1'($urandom_range(0, 1)), 1'b0, $urandom);
            6, 7:          do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            8:             do_divide(ra, rm, 0, 1'b1, 1'b1, $urandom);
            default:       do_idle();
         endcase
      end
      do_idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
